// File: rtl/cpu_pkg.sv
// Shared RV32I definitions: widths, NOP encoding, fetch entry layout, opcodes.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  // Opcode field [6:0] of the base integer ISA, shared with decode.
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count. Head data is
// presented combinationally; push and pop may coincide at any occupancy.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);
  // A pop frees the slot a same-cycle push lands in, so full+pop+push is legal.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointer and occupancy update; flush empties the FIFO and drops any push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage write; contents need no reset since r_count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_flush && w_full && !i_pop));

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC, credit-limited imem requests, in-order tag
// queue for returning PCs, and a fetch buffer feeding decode. Redirects flush
// the buffer and mark every in-flight response for discard.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;
  localparam logic [XLEN-1:0] RESET_PC_AL = RESET_PC & ~32'h3;

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_kill_cnt;
  logic [XLEN-1:0] r_hold_pc;
  logic [ILEN-1:0] r_hold_instr;

  logic [CW-1:0]   w_buf_count;
  logic [CW-1:0]   w_tag_count;
  logic [XLEN-1:0] w_tag_pc;
  logic [XLEN-1:0] w_redirect_pc;
  logic [SW-1:0]   w_slots_used;
  logic            w_credit;
  logic            w_grant;
  logic            w_resp_keep;
  logic            w_buf_pop;
  fetch_entry_t    w_buf_wdata;
  fetch_entry_t    w_head;

  assign w_redirect_pc = redirect_pc & ~32'h3;

  // Outstanding requests are exactly the tag queue occupancy. A slot being
  // popped this cycle counts as free: the response to a request issued now
  // cannot land before that pop has completed, which keeps 1 instr/cycle
  // with DEPTH=2 and single-cycle memory.
  assign w_slots_used = SW'(w_buf_count) + SW'(w_tag_count) - SW'(w_buf_pop);
  assign w_credit     = (w_slots_used < SW'(DEPTH));

  assign imem_req  = rst_n && !redirect_valid && w_credit;
  assign imem_addr = r_pc;
  assign w_grant   = imem_req && imem_gnt;

  // A response in the redirect cycle belongs to the old stream and is dropped.
  assign w_resp_keep = imem_rvalid && (r_kill_cnt == '0) && !redirect_valid;
  assign w_buf_pop   = id_valid && id_ready;
  assign w_buf_wdata = '{pc: w_tag_pc, instr: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_grant),
    .i_pop   (imem_rvalid),
    .i_flush (1'b0),
    .i_wdata (r_pc),
    .o_rdata (w_tag_pc),
    .o_count (w_tag_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(FETCH_ENTRY_W)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_resp_keep),
    .i_pop   (w_buf_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_buf_wdata),
    .o_rdata (w_head),
    .o_count (w_buf_count)
  );

  assign id_valid    = (w_buf_count != '0);
  assign id_instr    = id_valid ? w_head.instr : r_hold_instr;
  assign id_pc       = id_valid ? w_head.pc    : r_hold_pc;
  assign id_pc_plus4 = id_pc + 32'd4;

  // Next fetch address: redirect wins, otherwise step by a word on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_pc <= RESET_PC_AL;
    else if (redirect_valid) r_pc <= w_redirect_pc;
    else if (w_grant)        r_pc <= r_pc + 32'd4;
  end

  // Discard counter: on redirect every response still in flight after this
  // cycle is stale, which also covers responses already marked for discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_kill_cnt <= '0;
    else if (redirect_valid)
      r_kill_cnt <= w_tag_count - CW'(imem_rvalid);
    else if (imem_rvalid && (r_kill_cnt != '0))
      r_kill_cnt <= r_kill_cnt - CW'(1);
  end

  // Last-delivered entry shown to decode while the buffer is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_pc    <= RESET_PC;
      r_hold_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      r_hold_pc    <= RESET_PC;
      r_hold_instr <= NOP_INSTR;
    end else if (w_buf_pop) begin
      r_hold_pc    <= w_head.pc;
      r_hold_instr <= w_head.instr;
    end
  end

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (w_tag_count != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random grant/latency,
// stream scoreboard keyed by fetch epoch, plus directed timing checks.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          epoch;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t  sb_q[$];
  pend_t pend[$];
  int    epoch_ctr = 0;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  int    hs_count = 0;
  bit    scramble = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return scramble ? ((a ^ 32'h5A5A_0FF0) + 32'h0000_0013) : a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected fetch stream from a start address: consecutive words, 32-bit wrap.
  task automatic push_stream(input logic [31:0] start);
    logic [31:0] p;
    exp_t e;
    p = start & 32'hFFFF_FFFC;
    epoch_ctr++;
    for (int i = 0; i < 256; i++) begin
      e.epoch = epoch_ctr;
      e.pc    = p;
      e.instr = mem_word(p);
      sb_q.push_back(e);
      p = p + 32'd4;
    end
  endtask

  task automatic drop_old_epochs();
    int newest;
    if (sb_q.size() == 0) return;
    newest = sb_q[sb_q.size()-1].epoch;
    while (sb_q.size() > 0 && sb_q[0].epoch != newest) void'(sb_q.pop_front());
  endtask

  // Monitor: every accepted instruction must be the next one of the live stream.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      drop_old_epochs();
    end else begin
      if (id_valid && id_ready) begin
        hs_count++;
        chk("sb_avail", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sb_pc", id_pc, e.pc);
          chk("sb_instr", id_instr, e.instr);
          chk("sb_pc_plus4", id_pc_plus4, e.pc + 32'd4);
        end
      end
      if (redirect_valid) drop_old_epochs();
    end
  end

  task automatic capture(input int extra);
    pend_t p;
    if (imem_req && imem_gnt) begin
      p.addr = imem_addr;
      p.due  = cyc + 1 + extra;
      pend.push_back(p);
    end
  endtask

  // One clock cycle of stimulus; returns at the negedge of that cycle.
  task automatic step(input bit rdy, input bit g, input int extra,
                      input bit redir, input logic [31:0] rpc);
    @(posedge clk); #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    id_ready       = rdy;
    imem_gnt       = g;
    redirect_valid = redir;
    redirect_pc    = redir ? rpc : $urandom;
    if (redir) push_stream(rpc);
    @(negedge clk);
    capture(extra);
  endtask

  task automatic check_reset_outputs();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_pc", id_pc, RST_PC);
    chk("rst_id_pc_plus4", id_pc_plus4, RST_PC + 32'd4);
  endtask

  // Asynchronous reset asserted between clock edges; outputs checked at once.
  task automatic do_reset(input bit scr);
    @(posedge clk); #3;
    rst_n          = 1'b0;
    imem_rvalid    = 1'b0;
    imem_gnt       = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    pend.delete();
    scramble = scr;
    push_stream(RST_PC);
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
  endtask

  // Release reset; this is cycle 0, where the first request must appear.
  task automatic release_reset();
    @(posedge clk); #1;
    cyc++;
    rst_n          = 1'b1;
    imem_rvalid    = 1'b0;
    imem_gnt       = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rel_imem_req", 32'(imem_req), 32'd1);
    chk("rel_imem_addr", imem_addr, RST_PC);
    chk("rel_id_valid", 32'(id_valid), 32'd0);
    capture(0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int hs0;
    int since;
    bit redir;
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;

    // Reset, then free run from FFFF_FFF8 with identity memory (wraps to 0).
    do_reset(1'b0);
    release_reset();
    for (int i = 1; i < 12; i++) begin
      step(1, 1, 0, 0, 0);
      chk("free_id_valid", 32'(id_valid), 32'(i >= 2));
    end

    // Backpressure: buffer fills, requests stop, stream resumes in order.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0);
      chk("bp_imem_req", 32'(imem_req), 32'd0);
      chk("bp_id_valid", 32'(id_valid), 32'd1);
    end
    hs0 = hs_count;
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
    chk("bp_resume", 32'(hs_count - hs0 >= 9), 32'd1);

    // Redirect with two requests outstanding.
    k = 0;
    while (pend.size() != 2 && k < 20) begin
      step(1, 1, 2, 0, 0);
      k++;
    end
    chk("out2_reach", 32'(pend.size()), 32'd2);
    step(1, 1, 0, 1, 32'h0000_1002);
    hs0 = hs_count;
    for (int i = 0; i < 15; i++) step(1, 1, 0, 0, 0);
    chk("redir_progress", 32'(hs_count - hs0 >= 8), 32'd1);

    // Redirect coinciding with a response and a pop.
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 32'h0000_2000);
    chk("rp_pre", {29'd0, imem_rvalid, id_valid, imem_req}, 32'd6);
    step(1, 1, 0, 0, 0);
    chk("rp_r1_id_valid", 32'(id_valid), 32'd0);
    chk("rp_r1_id_instr", id_instr, NOP);
    chk("rp_r1_id_pc", id_pc, RST_PC);
    chk("rp_r1_imem_req", 32'(imem_req), 32'd1);
    chk("rp_r1_imem_addr", imem_addr, 32'h0000_2000);
    step(1, 1, 0, 0, 0);
    chk("rp_r2_id_valid", 32'(id_valid), 32'd0);
    step(1, 1, 0, 0, 0);
    chk("rp_r3_id_valid", 32'(id_valid), 32'd1);
    chk("rp_r3_id_pc", id_pc, 32'h0000_2000);

    // Random traffic with grant stalls, variable latency, redirects, and a reset.
    since = 0;
    hs0 = hs_count;
    for (int i = 0; i < 1200; i++) begin
      if (i == 600) begin
        do_reset(1'b1);
        release_reset();
        since = 0;
      end else begin
        redir = ($urandom_range(0, 24) == 0) || (since > 200);
        since = redir ? 0 : since + 1;
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 2), redir, $urandom);
      end
    end
    chk("rand_progress", 32'(hs_count - hs0 > 200), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
